// File: rtl/uart_rx_if.sv
// Byte-level UART receive bundle: pin-side inputs and received-frame outputs.
// The receiver core takes the master modport, the byte consumer the slave modport.
interface uart_rx_if #(
   parameter int unsigned PAYLOAD_BITS = 8
);
   logic                    uart_rxd;
   logic                    uart_rx_en;
   logic                    uart_rx_break;
   logic                    uart_rx_valid;
   logic [PAYLOAD_BITS-1:0] uart_rx_data;

   modport master (
      input  uart_rxd,
      input  uart_rx_en,
      output uart_rx_break,
      output uart_rx_valid,
      output uart_rx_data
   );

   modport slave (
      output uart_rxd,
      output uart_rx_en,
      input  uart_rx_break,
      input  uart_rx_valid,
      input  uart_rx_data
   );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver (LSB first, idle high) with mid-bit sampling,
// one-cycle valid strobe and BREAK detection.
module uart_rx_core #(
   parameter int unsigned BIT_RATE     = 9600,
   parameter int unsigned CLK_HZ       = 50000000,
   parameter int unsigned PAYLOAD_BITS = 8,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic      clk,
   input  logic      resetn,
   uart_rx_if.master rx
);

   localparam int unsigned CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
   localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;
   localparam int unsigned COUNT_W        = $clog2(CYCLES_PER_BIT + 1);
   localparam int unsigned IDX_W          = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

   localparam logic [COUNT_W-1:0] HalfLast = COUNT_W'(HALF_BIT - 1);
   localparam logic [COUNT_W-1:0] BitLast  = COUNT_W'(CYCLES_PER_BIT - 1);
   localparam logic [IDX_W-1:0]   IdxLast  = IDX_W'(PAYLOAD_BITS - 1);

   // Only the first stop bit is checked; extra stop bits simply read as idle.
   if (STOP_BITS < 1) begin : g_bad_stop_bits
      $error("STOP_BITS must be at least 1");
   end

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StStart    = 3'd1,
      StRecv     = 3'd2,
      StStop     = 3'd3,
      StWaitIdle = 3'd4
   } state_e;

   state_e                  state_q;
   logic [1:0]              sync_q;
   logic                    rxs;
   logic [COUNT_W-1:0]      cnt_q;
   logic [IDX_W-1:0]        idx_q;
   logic [PAYLOAD_BITS-1:0] shift_q;
   logic [PAYLOAD_BITS-1:0] shift_next;
   logic [PAYLOAD_BITS-1:0] data_q;
   logic                    valid_q;
   logic                    break_q;

   assign rxs              = sync_q[1];
   assign rx.uart_rx_valid = valid_q;
   assign rx.uart_rx_break = break_q;
   assign rx.uart_rx_data  = data_q;

   // Synchronizer resets to the idle (high) line level.
   always_ff @(posedge clk) begin
      if (resetn) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx.uart_rxd};
      end
   end

   always_comb begin
      shift_next        = shift_q;
      shift_next[idx_q] = rxs;
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         break_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         break_q <= 1'b0;
         if ((state_q != StIdle) && !rx.uart_rx_en) begin
            state_q <= StIdle;
            cnt_q   <= '0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (rx.uart_rx_en && !rxs) begin
                     state_q <= StStart;
                     cnt_q   <= '0;
                  end
               end
               StStart: begin
                  if (cnt_q == HalfLast) begin
                     cnt_q <= '0;
                     // A start bit that is high again at its midpoint was a glitch.
                     if (rxs) begin
                        state_q <= StIdle;
                     end else begin
                        state_q <= StRecv;
                        idx_q   <= '0;
                     end
                  end else begin
                     cnt_q <= cnt_q + COUNT_W'(1);
                  end
               end
               StRecv: begin
                  if (cnt_q == BitLast) begin
                     cnt_q   <= '0;
                     shift_q <= shift_next;
                     if (idx_q == IdxLast) begin
                        data_q  <= shift_next;
                        state_q <= StStop;
                     end else begin
                        idx_q <= idx_q + IDX_W'(1);
                     end
                  end else begin
                     cnt_q <= cnt_q + COUNT_W'(1);
                  end
               end
               StStop: begin
                  if (cnt_q == BitLast) begin
                     cnt_q <= '0;
                     if (rxs) begin
                        valid_q <= 1'b1;
                        state_q <= StIdle;
                     end else begin
                        // Low stop bit: BREAK if the payload is all zeros, else framing error.
                        if (shift_q == '0) begin
                           valid_q <= 1'b1;
                           break_q <= 1'b1;
                        end
                        state_q <= StWaitIdle;
                     end
                  end else begin
                     cnt_q <= cnt_q + COUNT_W'(1);
                  end
               end
               StWaitIdle: begin
                  if (rxs) begin
                     state_q <= StIdle;
                  end
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core at 50 MHz / 115200 b/s; delays are in ns units.
module tb_uart_rx_core;

   localparam int unsigned CLK_HZ   = 50000000;
   localparam int unsigned BIT_RATE = 115200;
   localparam int unsigned CPB      = CLK_HZ / BIT_RATE;  // 434
   localparam int          BIT_NS   = CPB * 20;           // 8680

   typedef struct packed {
      logic [7:0] data;
      logic       brk;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b1;

   uart_rx_if #(.PAYLOAD_BITS(8)) bus ();

   uart_rx_core #(
      .BIT_RATE    (BIT_RATE),
      .CLK_HZ      (CLK_HZ),
      .PAYLOAD_BITS(8),
      .STOP_BITS   (1)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .rx    (bus)
   );

   always #10 clk = ~clk;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass = 0;
   logic prev_pulse = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every strobe is popped against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (bus.uart_rx_valid || bus.uart_rx_break) begin
         check("pulse_single_cycle", {31'd0, prev_pulse}, 32'd0);
         if (bus.uart_rx_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_valid", {31'd0, bus.uart_rx_valid}, 32'd0);
            end else begin
               e = sb.pop_front();
               check("rx_data", {24'd0, bus.uart_rx_data}, {24'd0, e.data});
               check("rx_break", {31'd0, bus.uart_rx_break}, {31'd0, e.brk});
            end
         end else begin
            check("break_without_valid", {31'd0, bus.uart_rx_valid}, 32'd1);
         end
      end
      prev_pulse = bus.uart_rx_valid || bus.uart_rx_break;
   end

   task automatic send_frame(input logic [7:0] b, input logic stop, input logic exp_valid,
                             input string name);
      if (exp_valid) sb.push_back({b, (b == 8'h00) && !stop});
      bus.uart_rxd = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 8; i++) begin
         bus.uart_rxd = b[i];
         #(BIT_NS);
      end
      bus.uart_rxd = stop;
      #1000;
      check({name, "_data"}, {24'd0, bus.uart_rx_data}, {24'd0, b});
      #(BIT_NS - 1000);
      bus.uart_rxd = 1'b1;
      check({name, "_sb_drained"}, sb.size(), 32'd0);
      #1000;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      logic [7:0] vecs [10];
      vecs = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h01, 8'h80, 8'hC3, 8'h7E, 8'h96, 8'h2B};

      bus.uart_rxd   = 1'b1;
      bus.uart_rx_en = 1'b1;
      repeat (4) @(negedge clk);
      check("reset_valid", {31'd0, bus.uart_rx_valid}, 32'd0);
      check("reset_break", {31'd0, bus.uart_rx_break}, 32'd0);
      check("reset_data", {24'd0, bus.uart_rx_data}, 32'd0);
      check("reset_state", {29'd0, dut.state_q}, 32'd0);
      resetn = 1'b0;
      #1000;

      foreach (vecs[i]) send_frame(vecs[i], 1'b1, 1'b1, $sformatf("byte%0d", i));

      // Line held low for 12 bit times: exactly one BREAK strobe.
      sb.push_back({8'h00, 1'b1});
      bus.uart_rxd = 1'b0;
      #(12 * BIT_NS);
      check("break_seen", sb.size(), 32'd0);
      bus.uart_rxd = 1'b1;
      #(BIT_NS);
      check("break_idle_state", {29'd0, dut.state_q}, 32'd0);

      // Short low glitch on an idle line.
      bus.uart_rxd = 1'b0;
      #100;
      bus.uart_rxd = 1'b1;
      #(BIT_NS);
      check("glitch_idle_state", {29'd0, dut.state_q}, 32'd0);
      send_frame(8'h3C, 1'b1, 1'b1, "after_glitch");

      // Receiver disabled part way through 0x81.
      bus.uart_rxd = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) bus.uart_rx_en = 1'b0;
         bus.uart_rxd = i[0] ? 1'b0 : ((i == 0) || (i == 7)) ? 1'b1 : 1'b0;
         if ((i == 0) || (i == 7)) bus.uart_rxd = 1'b1;
         #(BIT_NS);
      end
      bus.uart_rxd = 1'b1;
      #(BIT_NS);
      check("disabled_data_kept", {24'd0, bus.uart_rx_data}, 32'h3C);
      check("disabled_state", {29'd0, dut.state_q}, 32'd0);
      bus.uart_rx_en = 1'b1;
      #1000;

      // Reset pulsed mid-frame; the line is released to idle with it.
      bus.uart_rxd = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 4; i++) begin
         bus.uart_rxd = i[0];
         #(BIT_NS);
      end
      @(negedge clk);
      resetn = 1'b1;
      bus.uart_rxd = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("midreset_data", {24'd0, bus.uart_rx_data}, 32'd0);
      check("midreset_valid", {31'd0, bus.uart_rx_valid}, 32'd0);
      check("midreset_state", {29'd0, dut.state_q}, 32'd0);
      resetn = 1'b0;
      #(2 * BIT_NS);
      send_frame(8'h42, 1'b1, 1'b1, "after_reset");

      // Framing error then recovery.
      send_frame(8'h11, 1'b0, 1'b0, "framing_err");
      send_frame(8'h22, 1'b1, 1'b1, "after_ferr");

      #(BIT_NS);
      check("sb_final_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Asynchronous serial (UART) receiver: 8N1 by default, LSB first, line idle high.
- Oversamples the receive pin with the system clock and samples each bit at its midpoint.
- Presents each received byte with a one-cycle valid strobe and flags BREAK conditions.
- Sits between the external RX pin and the byte-level consumer logic.

Parameters:
- BIT_RATE, 9600: line bit rate in bits/s.
- CLK_HZ, 50000000: clk frequency in Hz.
- PAYLOAD_BITS, 8: data bits per frame.
- STOP_BITS, 1: stop bits per frame; only the first is checked.
- CYCLES_PER_BIT (localparam), CLK_HZ/BIT_RATE with integer truncation: 434 at 50 MHz / 115200. It must be visible as a named constant for benches to read hierarchically.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- resetn  input  1  synchronous, active-high reset. Despite the name, asserted = 1.
- uart_rxd  input  1  asynchronous UART receive pin.
- uart_rx_en  input  1  receive enable.
- uart_rx_break  output  1  one-cycle pulse, with uart_rx_valid, when a BREAK is received.
- uart_rx_valid  output  1  one-cycle pulse: uart_rx_data holds a newly received frame.
- uart_rx_data  output  PAYLOAD_BITS  last received payload, held until overwritten.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: uart_rx_valid=0, uart_rx_break=0, uart_rx_data=0, FSM=IDLE, counters=0. The synchronizer resets to 1 (idle).
- Reset mid-frame aborts immediately and does not produce a valid.
- uart_rxd passes through a 2-flop synchronizer. All decisions use the synchronized value rxs.
- Bit counter width is clog2(CYCLES_PER_BIT+1). The payload bit index runs 0..PAYLOAD_BITS-1.
- FSM states and transitions:
  - IDLE: if uart_rx_en=1 and rxs=0, go to START and clear the cycle counter.
  - START: count to CYCLES_PER_BIT/2.
    - If rxs=1 at that point, it was a glitch; return to IDLE with no output.
    - Otherwise go to RECV, bit index 0, counter cleared.
  - RECV: every CYCLES_PER_BIT cycles, shift rxs into the payload register at the current index (LSB first).
    - After sampling bit PAYLOAD_BITS-1, copy the assembled payload to uart_rx_data in the same cycle, then go to STOP.
    - uart_rx_data therefore updates at mid-last-data-bit, before the stop bit.
  - STOP: after CYCLES_PER_BIT cycles (mid stop bit), sample rxs.
    - rxs=1: pulse uart_rx_valid for exactly one cycle; go to IDLE.
    - rxs=0 and payload all zeros (BREAK): pulse uart_rx_valid and uart_rx_break together for one cycle; go to WAIT_IDLE.
    - rxs=0 and payload nonzero (framing error): no valid, no break; uart_rx_data keeps the new value; go to WAIT_IDLE.
  - WAIT_IDLE: remain until rxs=1, then go to IDLE. A held-low line must not be re-detected as a start bit.
- uart_rx_en=0 in any non-IDLE state aborts to IDLE with no valid; uart_rx_data is unchanged.
- uart_rx_valid and uart_rx_break are never asserted for more than one consecutive cycle.
- Back-to-back frames: a new start bit is accepted from the first IDLE cycle after the stop-bit sample, so a minimum one-bit stop is supported.
- Tolerance: correct reception with up to ±2% bit-rate mismatch, given mid-bit sampling.

Test Plan:
- 50 MHz, 115200 b/s, 10 random bytes, each followed by a 1000 ns idle gap → uart_rx_data equals the byte 1000 ns after the stop bit starts; one uart_rx_valid pulse per byte; uart_rx_break=0.
- Frames 0x00 with valid stop, 0xFF, 0xA5, 0x5A → data matches exactly and LSB-first order is confirmed; 0x00 with stop=1 gives valid with break=0.
- Line held low for 12 bit times → one cycle with uart_rx_valid=1, uart_rx_break=1, data=0x00; no further valid until the line returns high and a new frame arrives.
- 100 ns low glitch on idle line → no valid, FSM back in IDLE; a following frame 0x3C is received correctly.
- uart_rx_en=0 while sending 0x81 → no valid, data unchanged; resetn pulsed high mid-frame → outputs 0, no valid for that frame, next frame 0x42 received correctly.
- Frame 0x11 with stop bit driven 0 (framing error) → no valid, no break; receiver recovers and receives 0x22 afterwards.
